// File: rtl/uart_pkg.sv
// Shared UART receive types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 347;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with registered head byte and head-valid outputs.
// Latency: a pushed byte appears at the head one cycle after the push edge.
// Backpressure: pop only when non-empty; push while full is ignored unless a pop frees a slot that cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             head_vld,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic             do_push, do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign wr_ptr_n = wr_ptr + (AW+1)'(do_push);
    assign rd_ptr_n = rd_ptr + (AW+1)'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head_dat <= '0;
            head_vld <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            head_vld <= (wr_ptr_n != rd_ptr_n);
            // The next head may be the slot being written this very cycle.
            if (wr_ptr_n != rd_ptr_n)
                head_dat <= (do_push && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) ?
                            din : mem[rd_ptr_n[AW-1:0]];
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with FIFO; UART_RX_PARITY_EN adds an even-parity bit.
// Latency: byte valid one cycle after the mid-stop-bit sample.
// Backpressure: rx_valid/rx_ready on the FIFO head; a full FIFO drops the byte and sets overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ser_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 clr_err,
    output logic                 parity_err
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);
    localparam int          BCW     = $clog2(DATA_BITS);

    rx_state_t            state;
    logic [1:0]           sync;
    logic                 rx_s, rx_prev;
    logic [15:0]          baud_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 baud_tick, stop_tick;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                 frame_evt, overrun_evt;
    logic                 par_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[0], ser_rx};
            rx_prev <= sync[1];
        end
    end

    assign rx_s        = sync[1];
    assign baud_tick   = (state == ST_START) ? (baud_cnt == HALF_M1) : (baud_cnt == BIT_M1);
    assign stop_tick   = (state == ST_STOP) && baud_tick;
    assign fifo_push   = stop_tick && rx_s && !par_bad;
    assign fifo_pop    = rx_valid && rx_ready;
    assign frame_evt   = stop_tick && !rx_s;
    assign overrun_evt = fifo_push && fifo_full && !fifo_pop;

`ifndef UART_RX_PARITY_EN
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            baud_cnt <= (state == ST_IDLE || baud_tick) ? '0 : baud_cnt + 16'd1;

            // Clear first so a coincident error event below wins.
            if (clr_err) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            if (frame_evt)
                frame_err <= 1'b1;
            if (overrun_evt)
                overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state   <= ST_START;
                        bit_cnt <= '0;
                        rx_busy <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        if (rx_s) begin
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        shreg[bit_cnt] <= rx_s;
                        bit_cnt        <= bit_cnt + 1'b1;
                        if (bit_cnt == BCW'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (baud_tick) begin
                        par_bad <= ((^shreg) != rx_s);
                        if ((^shreg) != rx_s)
                            parity_err <= 1'b1;
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_tick) begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .din      (shreg),
        .pop      (fifo_pop),
        .head_dat (rx_data),
        .head_vld (rx_valid),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed serial frames, expected bytes queued at send time
// and compared by an independent head-of-FIFO monitor.
module tb_uart_rx;

    localparam int CPB = 347;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;
    logic       clr_err;
    logic       parity_err;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    bit         chk_lat = 1'b0;
    bit         busy_d = 1'b0;
    int         valid_cycles = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_rx     (ser_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clr_err    (clr_err),
        .parity_err (parity_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        ser_rx = v;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++)
            send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored without parity build");
`endif
        send_bit(stop_v);
        ser_rx = 1'b1;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(1);
    endtask

    // Scoreboard monitor: every accepted head byte must match the queue front.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Busy falling edge marks the cycle after the stop sample: head must be valid then.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_lat) begin
                if (busy_d && !rx_busy)
                    chk("stop_to_valid_latency", {31'd0, rx_valid}, 32'd1);
                if (rx_valid)
                    valid_cycles++;
            end
            busy_d = rx_busy;
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        ser_rx   = 1'b1;
        rx_ready = 1'b0;
        clr_err  = 1'b0;
        tick(4);
        @(negedge clk);
        chk("rst_rx_valid",   {31'd0, rx_valid},   32'd0);
        chk("rst_rx_data",    {24'd0, rx_data},    32'd0);
        chk("rst_rx_busy",    {31'd0, rx_busy},    32'd0);
        chk("rst_frame_err",  {31'd0, frame_err},  32'd0);
        chk("rst_overrun",    {31'd0, overrun},    32'd0);
        chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(10);

        // Single byte, consumer always ready.
        rx_ready = 1'b1;
        chk_lat  = 1'b1;
        exp_q.push_back(8'h3D);
        send_byte(8'h3D, 1'b1, 1'b0);
        tick(5);
        chk_lat = 1'b0;
        chk("3d_valid_cycles", valid_cycles, 1);
        chk("3d_valid_after",  {31'd0, rx_valid},   32'd0);
        chk("3d_frame_err",    {31'd0, frame_err},  32'd0);
        chk("3d_overrun",      {31'd0, overrun},    32'd0);
        chk("3d_parity_err",   {31'd0, parity_err}, 32'd0);

        // Five back-to-back bytes into a four-deep FIFO with no consumer.
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1, 1'b0);
        end
        tick(5);
        chk("ovr_overrun_set", {31'd0, overrun},  32'd1);
        chk("ovr_head_held",   {24'd0, rx_data},  32'h01);
        chk("ovr_valid",       {31'd0, rx_valid}, 32'd1);
        rx_ready = 1'b1;
        for (int i = 0; i < 20 && rx_valid; i++) tick(1);
        chk("ovr_drained",      {31'd0, rx_valid}, 32'd0);
        chk("ovr_queue_empty",  exp_q.size(), 0);
        chk("ovr_still_sticky", {31'd0, overrun}, 32'd1);
        pulse_clr();
        chk("ovr_cleared",      {31'd0, overrun}, 32'd0);

        // Stop bit forced low, then a clean frame of the same byte.
        send_byte(8'h0F, 1'b0, 1'b0);
        tick(CPB);
        chk("fe_frame_err", {31'd0, frame_err}, 32'd1);
        chk("fe_no_valid",  {31'd0, rx_valid},  32'd0);
        pulse_clr();
        chk("fe_cleared",   {31'd0, frame_err}, 32'd0);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1, 1'b0);
        tick(5);
        chk("fe_next_ok_err", {31'd0, frame_err}, 32'd0);

        // Short low glitch is rejected at the mid-start sample.
        ser_rx = 1'b0;
        tick(CPB / 4);
        ser_rx = 1'b1;
        tick(10);
        chk("glitch_busy_in_start", {31'd0, rx_busy}, 32'd1);
        tick(CPB);
        chk("glitch_busy_dropped",  {31'd0, rx_busy},   32'd0);
        chk("glitch_no_valid",      {31'd0, rx_valid},  32'd0);
        chk("glitch_no_frame_err",  {31'd0, frame_err}, 32'd0);

        // Reset in the middle of data bit 4 of 0xAB, then a clean 0x51.
        begin
            logic [7:0] ab;
            ab = 8'hAB;
            send_bit(1'b0);
            for (int i = 0; i < 4; i++) send_bit(ab[i]);
            ser_rx = ab[4];
            tick(CPB / 2);
            chk("rst_mid_busy_before", {31'd0, rx_busy}, 32'd1);
            rst_n  = 1'b0;
            ser_rx = 1'b1;
            tick(4);
            chk("rst_mid_busy",  {31'd0, rx_busy},  32'd0);
            chk("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
            rst_n = 1'b1;
            tick(2 * CPB);
            chk("rst_mid_idle_valid", {31'd0, rx_valid}, 32'd0);
        end
        exp_q.push_back(8'h51);
        send_byte(8'h51, 1'b1, 1'b0);
        tick(5);
        chk("rst_mid_flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);

`ifdef UART_RX_PARITY_EN
        // Odd parity bit on 0x07 is discarded; correct parity is delivered.
        send_byte(8'h07, 1'b1, 1'b1);
        tick(5);
        chk("par_err_set",   {31'd0, parity_err}, 32'd1);
        chk("par_discarded", {31'd0, rx_valid},   32'd0);
        pulse_clr();
        chk("par_cleared",   {31'd0, parity_err}, 32'd0);
        exp_q.push_back(8'h07);
        send_byte(8'h07, 1'b1, 1'b0);
        tick(5);
        chk("par_ok_no_err", {31'd0, parity_err}, 32'd0);
`endif

        tick(10);
        chk("all_bytes_delivered", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
